// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit. It holds the PC and issues word fetches under a
// request/grant protocol. Returned words go into a small in-order FIFO that
// feeds the decoder. A redirect flushes the FIFO, and responses to requests
// already in flight are dropped.
module instruction_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRespValid,
    input  logic [XLEN-1:0] imemRespData,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    output logic            instValid,
    input  logic            instReady,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instPc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    // Registered state
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             running_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic [XLEN-1:0]  inst_pc_q, inst_pc_d;

    logic [XLEN-1:0]  fifo_word_q [BUF_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q   [BUF_DEPTH];
    logic [XLEN-1:0]  iq_pc_q     [BUF_DEPTH];

    // Per-cycle events
    logic             pop, grant, push;
    logic [SUM_W-1:0] req_sum;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [XLEN-1:0]  resp_pc;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirectPc[1:0];

    assign imemAddr    = pc_q;
    assign instValid   = valid_q;
    assign instruction = inst_q;
    assign instPc      = inst_pc_q;

    // Request when buffered plus in-flight words, less this cycle's pop, leave room
    always_comb begin
        pop     = valid_q && instReady;
        req_sum = SUM_W'(count_q) + SUM_W'(outst_q) - SUM_W'(pop);
        imemReq = running_q && (req_sum < SUM_W'(BUF_DEPTH));
        grant   = imemReq && imemGnt;
    end

    // Next-state: pc, counters, FIFO pointers and the registered head
    always_comb begin
        resp_pc       = iq_pc_q[iq_rd_q];
        push          = imemRespValid && (discard_q == '0) && !redirectValid;

        pc_d          = grant ? pc_q + XLEN'(4) : pc_q;
        outst_d       = outst_q + CNT_W'(grant) - CNT_W'(imemRespValid);
        discard_d     = (imemRespValid && discard_q != '0) ? discard_q - CNT_W'(1) : discard_q;
        iq_wr_d       = iq_wr_q + PTR_W'(grant);
        iq_rd_d       = iq_rd_q + PTR_W'(imemRespValid);

        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        cnt_after_pop = count_q - CNT_W'(pop);
        count_d       = cnt_after_pop + CNT_W'(push);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);

        if (redirectValid) begin
            pc_d      = {redirectPc[XLEN-1:2], 2'b00};
            discard_d = outst_d;
            count_d   = '0;
            wr_ptr_d  = rd_ptr_d;
        end

        valid_d   = (count_d != '0);
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (count_d != '0) begin
            if (cnt_after_pop != '0) begin
                inst_d    = fifo_word_q[rd_ptr_d];
                inst_pc_d = fifo_pc_q[rd_ptr_d];
            end else begin
                inst_d    = imemRespData;
                inst_pc_d = resp_pc;
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            running_q <= 1'b0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            iq_rd_q   <= '0;
            iq_wr_q   <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            running_q <= 1'b1;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            iq_rd_q   <= iq_rd_d;
            iq_wr_q   <= iq_wr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // FIFO and issue-pc storage; contents only meaningful under the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word_q[wr_ptr_q] <= imemRespData;
            fifo_pc_q[wr_ptr_q]   <= resp_pc;
        end
        if (grant) begin
            iq_pc_q[iq_wr_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A behavioural memory answers
// each fetch with the inverted address, with configurable latency and grant.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instValid;
    logic        instReady;
    logic [31:0] instruction;
    logic [31:0] instPc;

    int n_vec = 0;
    int n_err = 0;

    logic gnt_rand = 1'b0;
    logic rnd_gnt;
    int   lat_min = 1;
    int   lat_max = 1;
    int   edge_n;
    int   mem_lat;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always #5 clk = ~clk;

    assign imemGnt = gnt_rand ? rnd_gnt : 1'b1;

    instruction_fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .instValid(instValid), .instReady(instReady),
        .instruction(instruction), .instPc(instPc)
    );

    // In-order memory: a grant at edge e returns at the earliest in the cycle after edge e+lat-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            imemRespValid <= 1'b0;
            imemRespData  <= '0;
            rnd_gnt       <= 1'b0;
            edge_n        <= 0;
        end else begin
            if (imemRespValid) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (imemReq && imemGnt) begin
                mem_lat = $urandom_range(lat_max, lat_min);
                q_addr.push_back(imemAddr);
                q_due.push_back(edge_n + mem_lat - 1);
            end
            if (q_addr.size() > 0 && q_due[0] <= edge_n) begin
                imemRespValid <= 1'b1;
                imemRespData  <= ~q_addr[0];
            end else begin
                imemRespValid <= 1'b0;
            end
            edge_n  <= edge_n + 1;
            rnd_gnt <= 1'($urandom_range(1, 0));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse reset across two negedges and release it; the next negedge is mid-C1
    task automatic restart();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_before_first_edge", 32'(imemReq), 32'd0);
        chk("addr_after_release", imemAddr, 32'h0);
    endtask

    int          pops;
    logic [31:0] exp_pc;

    initial begin
        rst_n         = 1'b0;
        instReady     = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = '0;

        // Reset values
        @(negedge clk);
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, 32'h0);
        chk("rst_valid", 32'(instValid), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", instPc, 32'h0);

        // Streaming with a 1-cycle memory
        restart();
        @(negedge clk);
        chk("a_c1_req", 32'(imemReq), 32'd1);
        chk("a_c1_addr", imemAddr, 32'h0);
        chk("a_c1_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("a_c2_addr", imemAddr, 32'h4);
        chk("a_c2_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("a_c3_valid", 32'(instValid), 32'd1);
        chk("a_c3_pc", instPc, 32'h0);
        chk("a_c3_instr", instruction, ~32'h0);
        chk("a_c3_addr", imemAddr, 32'h8);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("a_stream_valid", 32'(instValid), 32'd1);
            chk("a_stream_pc", instPc, 32'(4 * i));
            chk("a_stream_instr", instruction, ~32'(4 * i));
            chk("a_stream_req", 32'(imemReq), 32'd1);
        end

        // Backpressure: head holds, buffer fills, request drops
        instReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req", 32'(imemReq), 32'd0);
            chk("bp_valid", 32'(instValid), 32'd1);
            chk("bp_pc", instPc, 32'h10);
            chk("bp_instr", instruction, ~32'h10);
            chk("bp_addr", imemAddr, 32'h18);
        end
        instReady = 1'b1;
        #1;
        chk("bp_req_on_pop", 32'(imemReq), 32'd1);
        @(negedge clk);
        chk("bp_next_pc", instPc, 32'h14);
        @(negedge clk);
        chk("bp_next2_pc", instPc, 32'h18);

        // Redirect with two outstanding (3-cycle memory)
        lat_min = 3;
        lat_max = 3;
        restart();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd_full_req", 32'(imemReq), 32'd0);
        chk("rd_full_addr", imemAddr, 32'h8);
        redirectValid = 1'b1;
        redirectPc    = 32'h103;
        @(negedge clk);
        redirectValid = 1'b0;
        chk("rd_c4_valid", 32'(instValid), 32'd0);
        chk("rd_c4_addr", imemAddr, 32'h100);
        chk("rd_c4_req", 32'(imemReq), 32'd0);
        @(negedge clk);
        chk("rd_c5_req", 32'(imemReq), 32'd1);
        chk("rd_c5_addr", imemAddr, 32'h100);
        chk("rd_c5_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("rd_c6_addr", imemAddr, 32'h104);
        chk("rd_c6_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("rd_c7_req", 32'(imemReq), 32'd0);
        chk("rd_c7_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("rd_c8_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        chk("rd_c9_valid", 32'(instValid), 32'd1);
        chk("rd_c9_pc", instPc, 32'h100);
        chk("rd_c9_instr", instruction, ~32'h100);
        @(negedge clk);
        chk("rd_c10_pc", instPc, 32'h104);

        // Redirect coincident with a response, a grant and a pop
        lat_min = 1;
        lat_max = 1;
        restart();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rc_c3_pc", instPc, 32'h0);
        chk("rc_c3_req", 32'(imemReq), 32'd1);
        redirectValid = 1'b1;
        redirectPc    = 32'h200;
        @(negedge clk);
        redirectValid = 1'b0;
        chk("rc_c4_valid", 32'(instValid), 32'd0);
        chk("rc_c4_addr", imemAddr, 32'h200);
        chk("rc_c4_req", 32'(imemReq), 32'd1);
        @(negedge clk);
        chk("rc_c5_valid", 32'(instValid), 32'd0);
        chk("rc_c5_addr", imemAddr, 32'h204);
        @(negedge clk);
        chk("rc_c6_valid", 32'(instValid), 32'd1);
        chk("rc_c6_pc", instPc, 32'h200);
        chk("rc_c6_instr", instruction, ~32'h200);
        @(negedge clk);
        chk("rc_c7_pc", instPc, 32'h204);

        // Random grant, 1-4 cycle latency, random ready: ordered, gap-free stream
        lat_min  = 1;
        lat_max  = 4;
        gnt_rand = 1'b1;
        restart();
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            instReady = 1'($urandom_range(1, 0));
            #1;
            if (instValid) begin
                chk("var_pc", instPc, exp_pc);
                chk("var_instr", instruction, ~exp_pc);
                if (instReady) begin
                    exp_pc = exp_pc + 32'h4;
                    pops++;
                end
            end
        end
        chk("var_progress", 32'(pops >= 30), 32'd1);

        // Asynchronous reset between edges, then restart from RESET_PC
        gnt_rand  = 1'b0;
        lat_max   = 1;
        instReady = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(imemReq), 32'd0);
        chk("ar_addr", imemAddr, 32'h0);
        chk("ar_valid", 32'(instValid), 32'd0);
        chk("ar_instr", instruction, 32'h0);
        chk("ar_pc", instPc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_req_hold", 32'(imemReq), 32'd0);
        @(negedge clk);
        chk("ar_c1_req", 32'(imemReq), 32'd1);
        chk("ar_c1_addr", imemAddr, 32'h0);
        @(negedge clk);
        chk("ar_c2_addr", imemAddr, 32'h4);
        @(negedge clk);
        chk("ar_c3_valid", 32'(instValid), 32'd1);
        chk("ar_c3_pc", instPc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
